// File: rtl/scipio_pkg.sv
// Shared issue-path types and constants for the execution-unit issue arbiter.
package scipio_pkg;

  localparam int N_REQ_DEF  = 4;
  localparam int TAG_W_DEF  = 5;
  localparam int DATA_W_DEF = 32;
  localparam int OP_W_DEF   = 4;

  // Reserved rename tag shown on the issue port whenever the slot is empty.
  localparam logic [TAG_W_DEF-1:0] TAG_INVALID = '1;

  // Execution opcodes understood by the shared unit.
  typedef enum logic [OP_W_DEF-1:0] {
    EX_OP_NOP = 4'h0,
    EX_OP_ADD = 4'h1,
    EX_OP_SUB = 4'h2,
    EX_OP_AND = 4'h3,
    EX_OP_OR  = 4'h4,
    EX_OP_XOR = 4'h5,
    EX_OP_SLL = 4'h6,
    EX_OP_SRL = 4'h7,
    EX_OP_SRA = 4'h8,
    EX_OP_SLT = 4'h9
  } ex_op_e;

  // Contents of one issue slot.
  typedef struct packed {
    ex_op_e                op;
    logic [DATA_W_DEF-1:0] a;
    logic [DATA_W_DEF-1:0] b;
    logic [TAG_W_DEF-1:0]  tag;
  } issue_slot_t;

endpackage

// File: rtl/ex_issue_arb_rr_arbiter.sv
// Round-robin arbiter: searches from the owned pointer with wrap-around and
// advances the pointer past the winner only when a grant is actually issued.
module rr_arbiter #(
  parameter int N = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             en,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             grant_any
);

  localparam int IW = PTR_W + 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] idx_sel;
  logic             found;
  logic [IW-1:0]    sum;

  // Find the first requester at or after the pointer, wrapping at N.
  always_comb begin
    found   = 1'b0;
    idx_sel = '0;
    sum     = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_q} + IW'(k);
      if (sum >= IW'(N)) begin
        sum = sum - IW'(N);
      end
      if (!found && req[sum[PTR_W-1:0]]) begin
        found   = 1'b1;
        idx_sel = sum[PTR_W-1:0];
      end
    end
  end

  // Drive the one-hot grant and compute the pointer that follows the winner.
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    if (en && found) begin
      grant[idx_sel] = 1'b1;
      if (idx_sel == PTR_W'(N - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = idx_sel + PTR_W'(1);
      end
    end
  end

  assign grant_idx = idx_sel;
  assign grant_any = en && found;

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ex_issue_arb.sv
// Issue arbiter: grants one ready reservation station per cycle into a single
// issue slot feeding the shared execution unit, with valid/ready backpressure
// and flush. Optional perf counters are built when ISSUE_PERF_CNT_EN is defined.
module ex_issue_arb
  import scipio_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*OP_W-1:0]   req_op,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  output logic                    ex_valid,
  input  logic                    ex_ready,
  output logic [OP_W-1:0]         ex_op,
  output logic [DATA_W-1:0]       ex_a,
  output logic [DATA_W-1:0]       ex_b,
  output logic [TAG_W-1:0]        ex_tag,
  output logic [31:0]             perf_issue_cnt,
  output logic [31:0]             perf_stall_cnt
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [TAG_W-1:0] TAG_INV = {TAG_W{1'b1}};

  logic [OP_W-1:0]   op_arr  [N_REQ];
  logic [DATA_W-1:0] a_arr   [N_REQ];
  logic [DATA_W-1:0] b_arr   [N_REQ];
  logic [TAG_W-1:0]  tag_arr [N_REQ];

  logic             can_load;
  logic [N_REQ-1:0] grant;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_any;

  logic              ex_valid_q, ex_valid_d;
  logic [OP_W-1:0]   ex_op_q,    ex_op_d;
  logic [DATA_W-1:0] ex_a_q,     ex_a_d;
  logic [DATA_W-1:0] ex_b_q,     ex_b_d;
  logic [TAG_W-1:0]  ex_tag_q,   ex_tag_d;

  // Unpack the per-station buses.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign op_arr[gi]  = req_op[gi*OP_W +: OP_W];
    assign a_arr[gi]   = req_a[gi*DATA_W +: DATA_W];
    assign b_arr[gi]   = req_b[gi*DATA_W +: DATA_W];
    assign tag_arr[gi] = req_tag[gi*TAG_W +: TAG_W];
  end

  // The slot can take a new instruction when empty or draining this cycle.
  assign can_load = !flush && (!ex_valid_q || ex_ready);

  rr_arbiter #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .en        (can_load),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready = grant;

  // Slot next state: flush wins, then load/empty when free, else hold.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_op_d    = ex_op_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    ex_tag_d   = ex_tag_q;
    if (flush) begin
      ex_valid_d = 1'b0;
      ex_tag_d   = TAG_INV;
    end else if (can_load) begin
      if (grant_any) begin
        ex_valid_d = 1'b1;
        ex_op_d    = op_arr[grant_idx];
        ex_a_d     = a_arr[grant_idx];
        ex_b_d     = b_arr[grant_idx];
        ex_tag_d   = tag_arr[grant_idx];
      end else begin
        ex_valid_d = 1'b0;
        ex_tag_d   = TAG_INV;
      end
    end
  end

  // Issue slot register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_tag_q   <= TAG_INV;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_tag_q   <= ex_tag_d;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_op    = ex_op_q;
  assign ex_a     = ex_a_q;
  assign ex_b     = ex_b_q;
  assign ex_tag   = ex_tag_q;

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] issue_cnt_q, issue_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count grant-driven loads and backpressure cycles; wrap naturally.
  always_comb begin
    issue_cnt_d = issue_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (grant_any) begin
      issue_cnt_d = issue_cnt_q + 32'd1;
    end
    if (ex_valid_q && !ex_ready) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_issue_cnt = issue_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_issue_cnt = 32'd0;
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: doc/ex_issue_arb.md
Name: ex_issue_arb

Overview:
- Round-robin arbiter and issue register between the reservation stations and one shared execution unit.
- Up to N_REQ stations present ready instructions each cycle. The block grants one of them and registers its op, operands and destination tag into a single issue slot feeding the unit.
- It applies valid/ready backpressure from the unit and discards in-flight work on a pipeline flush.

Parameters:
- N_REQ, 4, number of requesting reservation stations.
- TAG_W, 5, width of the destination rename tag.
- DATA_W, 32, operand width.
- OP_W, 4, execution opcode width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  squash all in-flight issue state.
- req_valid  in  N_REQ  station i holds a ready instruction.
- req_ready  out  N_REQ  one-hot grant; station i's instruction is accepted this cycle.
- req_op  in  N_REQ*OP_W  packed opcodes, station i at [i*OP_W +: OP_W].
- req_a  in  N_REQ*DATA_W  packed operand A.
- req_b  in  N_REQ*DATA_W  packed operand B.
- req_tag  in  N_REQ*TAG_W  packed destination tags.
- ex_valid  out  1  issue slot holds a valid instruction.
- ex_ready  in  1  execution unit accepts the slot this cycle.
- ex_op  out  OP_W  issued opcode.
- ex_a  out  DATA_W  issued operand A.
- ex_b  out  DATA_W  issued operand B.
- ex_tag  out  TAG_W  issued destination tag; TAG_INVALID when ex_valid=0.
- perf_issue_cnt  out  32  issue counter; see Optional Feature.
- perf_stall_cnt  out  32  backpressure counter; see Optional Feature.

Behaviour:
- Reset (async, rst=1):
  - ex_valid=0, ex_op=0, ex_a=0, ex_b=0, ex_tag=TAG_INVALID.
  - Round-robin pointer ptr=0.
  - Both perf counters = 0.
  - Reset mid-transfer drops the slot content with no handshake.
- Slot load condition: can_load = !flush && (!ex_valid || ex_ready).
- Grant (combinational):
  - When can_load, grant the first asserted req_valid searching i = ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1 (wrap-around).
  - req_ready = grant when can_load, otherwise all zeros.
  - At most one bit of req_ready is set.
- Transfers:
  - A station's instruction transfers on req_valid[i] && req_ready[i].
  - The slot transfers to the unit on ex_valid && ex_ready.
- Next state at clk edge:
  - flush=1: ex_valid<=0, ex_tag<=TAG_INVALID, ptr unchanged. Flush takes priority over both the grant and ex_ready.
  - Grant issued: slot <= granted op/a/b/tag, ex_valid<=1, ptr <= (granted index+1) mod N_REQ.
  - can_load but no request: ex_valid<=0, ex_tag<=TAG_INVALID, ptr unchanged.
  - Stalled (ex_valid && !ex_ready): all slot fields hold stable, no grant.
- Timing:
  - Issue latency: one cycle from grant to ex_valid.
  - Throughput: one instruction per cycle while ex_ready=1 (back-to-back: ex_ready and a new grant in the same cycle).
- Data fields are don't-care while ex_valid=0, except ex_tag, which must read TAG_INVALID.
- A requester that drops req_valid without being granted is simply not granted. No state is kept per requester.

Optional Feature:
- Macro ISSUE_PERF_CNT_EN.
- Defined:
  - perf_issue_cnt increments on each slot load from a grant.
  - perf_stall_cnt increments on each cycle with ex_valid && !ex_ready.
  - Both are 32-bit, wrap at 2^32-1 -> 0, and clear on rst only (not on flush).
- Undefined: no counter flops; both ports tied to 0.

Decomposition:
- Shared package scipio_pkg holds:
  - TAG_INVALID (all ones, TAG_W bits).
  - The ex opcode enum (OP_W wide).
  - An issue_slot_t struct {op, a, b, tag}.
- Sub-module rr_arbiter:
  - Parameter N.
  - Ports req[N], en, grant[N] one-hot, owned pointer register.
  - The pointer advances only when en && |req.
- ex_issue_arb instantiates rr_arbiter, the slot register and the optional counters.

Test Plan:
- Reset, then req_valid=4'b1111 with ex_ready=1 for 4 cycles -> grants 0,1,2,3 in order; ex_tag equals each station's tag one cycle later; perf_issue_cnt=4 when enabled.
- ptr=3, req_valid=4'b0011 -> grant station 0 (wrap); next grant station 1.
- Slot valid (tag 5'h0A), ex_ready=0 for 3 cycles with req_valid=4'b0100 -> req_ready=0; ex_* stable; perf_stall_cnt=3. ex_ready=1 -> station 2 granted the same cycle.
- flush=1 while ex_valid=1 and req_valid=4'b1000 -> req_ready=0; next cycle ex_valid=0 and ex_tag=TAG_INVALID; ptr unchanged.
- rst asserted mid-stall with ex_valid=1 -> ex_valid=0 immediately, without waiting for a clock edge; first post-reset grant goes to the lowest requesting index.
- Randomized req_valid/ex_ready for 10k cycles -> req_ready always one-hot or zero; every grant appears on ex_* exactly once; no requester waits more than N_REQ-1 grants while continuously valid.
